// File: rtl/zig_zag_pp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | zig_zag_pp : 8x8 raster-to-zig-zag reorder over an N-deep block ring         |
// | Optional feature macro: ZZ_LAST_NZ_EN (adds m_last_nz_o)                     |
// | Revision   : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module zig_zag_pp #(
  parameter int DCT_WIDTH = 12,
  parameter int NUM_BUFS  = 2,
  parameter int CH_WIDTH  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DCT_WIDTH-1:0] s_tdata_i,
  input  logic                 s_tvalid_i,
  output logic                 s_tready_o,
  input  logic                 s_tlast_i,
  input  logic [CH_WIDTH-1:0]  s_tuser_i,
  input  logic                 raster_i,
  output logic [DCT_WIDTH-1:0] m_tdata_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic                 m_tlast_o,
  output logic [CH_WIDTH-1:0]  m_tuser_o,
`ifdef ZZ_LAST_NZ_EN
  output logic                 m_last_nz_o,
`endif
  output logic                 err_o
);

  localparam int PTR_W = (NUM_BUFS > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } buf_state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_BUFS - 1) return '0;
    return PTR_W'(int'(p) + 1);
  endfunction

  // Zig-zag scan position of raster position k, walking the anti-diagonals.
  function automatic logic [5:0] zz_index(input logic [5:0] k);
    int r, c, s, base, off;
    r = int'(k[5:3]);
    c = int'(k[2:0]);
    s = r + c;
    if (s < 8) begin
      base = s * (s + 1) / 2;
      off  = ((s % 2) == 1) ? r : c;
    end else begin
      base = 64 - (15 - s) * (16 - s) / 2;
      off  = ((s % 2) == 1) ? (r - (s - 7)) : (c - (s - 7));
    end
    return 6'(base + off);
  endfunction

  logic [DCT_WIDTH-1:0] mem      [NUM_BUFS][64];
  logic [CH_WIDTH-1:0]  user_mem [NUM_BUFS];
  buf_state_t           state     [NUM_BUFS];
  buf_state_t           state_nxt [NUM_BUFS];

  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, out_buf;
  logic [5:0]       wr_cnt, rd_addr, wr_addr;
  logic             wr_raster, wr_mode, wr_first, wr_end, wr_fire;
  logic             out_fire, out_adv, rd_bypass, rd_avail, rd_fetch, ready_nxt;

  assign wr_fire  = s_tvalid_i & s_tready_o;
  assign wr_first = (wr_cnt == 6'd0);
  assign wr_end   = (wr_cnt == 6'd63);
  assign wr_mode  = wr_first ? raster_i : wr_raster;
  assign wr_addr  = wr_mode ? wr_cnt : zz_index(wr_cnt);

  assign out_fire = m_tvalid_o & m_tready_i;
  assign out_adv  = ~m_tvalid_o | m_tready_i;

  // Output address 0 is always written on beat 0, so a block can start
  // draining on the very edge its last beat lands.
  assign rd_bypass = wr_fire & wr_end & (wr_ptr == rd_ptr);
  assign rd_avail  = (state[rd_ptr] == FULL) | (state[rd_ptr] == DRAINING) | rd_bypass;
  assign rd_fetch  = out_adv & rd_avail;

  always_comb begin
    for (int b = 0; b < NUM_BUFS; b++) state_nxt[b] = state[b];
    if (wr_fire && wr_first) state_nxt[wr_ptr] = FILLING;
    if (wr_fire && wr_end)   state_nxt[wr_ptr] = FULL;
    if (rd_fetch && (rd_addr == 6'd0)) state_nxt[rd_ptr] = DRAINING;
    if (out_fire && m_tlast_o) state_nxt[out_buf] = EMPTY;
  end

  assign wr_ptr_nxt = (wr_fire && wr_end) ? ptr_inc(wr_ptr) : wr_ptr;
  assign ready_nxt  = (state_nxt[wr_ptr_nxt] == EMPTY) | (state_nxt[wr_ptr_nxt] == FILLING);

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[wr_ptr][wr_addr] <= s_tdata_i;
      if (wr_first) user_mem[wr_ptr] <= s_tuser_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NUM_BUFS; b++) state[b] <= EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_buf    <= '0;
      wr_cnt     <= 6'd0;
      rd_addr    <= 6'd0;
      wr_raster  <= 1'b0;
      s_tready_o <= 1'b0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tlast_o  <= 1'b0;
      m_tuser_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BUFS; b++) state[b] <= state_nxt[b];
      wr_ptr     <= wr_ptr_nxt;
      s_tready_o <= ready_nxt;

      if (wr_fire) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_first) wr_raster <= raster_i;
        // tlast is advisory; the beat counter alone frames the block.
        if (s_tlast_i != wr_end) err_o <= 1'b1;
      end

      if (out_adv) begin
        m_tvalid_o <= rd_avail;
        if (rd_avail) begin
          m_tdata_o <= mem[rd_ptr][rd_addr];
          m_tlast_o <= (rd_addr == 6'd63);
          m_tuser_o <= user_mem[rd_ptr];
          out_buf   <= rd_ptr;
          rd_addr   <= rd_addr + 6'd1;
          if (rd_addr == 6'd63) rd_ptr <= ptr_inc(rd_ptr);
        end
      end
    end
  end

`ifdef ZZ_LAST_NZ_EN
  logic [5:0] last_nz [NUM_BUFS];
  logic [5:0] last_nz_upd, rd_last_nz;
  logic       coeff_nz;

  assign coeff_nz = |s_tdata_i;

  always_comb begin
    last_nz_upd = last_nz[wr_ptr];
    if (wr_first)                                    last_nz_upd = coeff_nz ? wr_addr : 6'd0;
    else if (coeff_nz && (wr_addr > last_nz[wr_ptr])) last_nz_upd = wr_addr;
  end

  assign rd_last_nz = rd_bypass ? last_nz_upd : last_nz[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NUM_BUFS; b++) last_nz[b] <= 6'd0;
      m_last_nz_o <= 1'b0;
    end else begin
      if (wr_fire) last_nz[wr_ptr] <= last_nz_upd;
      if (rd_fetch) m_last_nz_o <= (rd_addr == rd_last_nz);
    end
  end
`endif

endmodule
`default_nettype wire
